// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a single i2c_master.
// Owns the master from grant until done, or until err when the master never starts.
module i2c_arbiter #(
    parameter int START_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         r0_req,
    input  logic [6:0]   r0_addr,
    input  logic [127:0] r0_data,
    input  logic [4:0]   r0_packets,
    input  logic         r0_rw,
    input  logic         r1_req,
    input  logic [6:0]   r1_addr,
    input  logic [127:0] r1_data,
    input  logic [4:0]   r1_packets,
    input  logic         r1_rw,
    output logic         r0_grant,
    output logic         r0_done,
    output logic         r0_err,
    output logic         r1_grant,
    output logic         r1_done,
    output logic         r1_err,
    output logic [127:0] rd_data,
    output logic [6:0]   m_addr,
    output logic [127:0] m_data,
    output logic [4:0]   m_packets,
    output logic         m_rw,
    output logic         m_start,
    input  logic         m_ready,
    input  logic [127:0] m_data_out
);

    localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t        state;
    logic          last_winner;
    logic          owner;
    logic [CW-1:0] tmo_cnt;
    logic          winner;
    logic          any_req;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        any_req = r0_req | r1_req;
        winner  = r1_req;
        if (r0_req && r1_req) winner = ~last_winner;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            owner       <= 1'b0;
            tmo_cnt     <= '0;
            r0_grant    <= 1'b0;
            r1_grant    <= 1'b0;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
            r0_err      <= 1'b0;
            r1_err      <= 1'b0;
            rd_data     <= '0;
            m_addr      <= '0;
            m_data      <= '0;
            m_packets   <= '0;
            m_rw        <= 1'b0;
            m_start     <= 1'b0;
        end else begin
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            r0_err  <= 1'b0;
            r1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_ready && any_req) begin
                        owner     <= winner;
                        m_addr    <= winner ? r1_addr    : r0_addr;
                        m_data    <= winner ? r1_data    : r0_data;
                        m_packets <= winner ? r1_packets : r0_packets;
                        m_rw      <= winner ? r1_rw      : r0_rw;
                        r0_grant  <= ~winner;
                        r1_grant  <= winner;
                        m_start   <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    // A master that took the request wins over a timeout in the same cycle.
                    if (!m_ready) begin
                        m_start <= 1'b0;
                        state   <= BUSY;
                    end else if (tmo_cnt == CNT_LAST) begin
                        m_start  <= 1'b0;
                        r0_grant <= 1'b0;
                        r1_grant <= 1'b0;
                        r0_err   <= ~owner;
                        r1_err   <= owner;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        if (m_rw) rd_data <= m_data_out;
                        r0_done <= ~owner;
                        r1_done <= owner;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    r0_grant    <= 1'b0;
                    r1_grant    <= 1'b0;
                    last_winner <= owner;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized scoreboard bench for i2c_arbiter: transaction-level model of the
// arbitration rules and a behavioural i2c_master, checked by a separate monitor.
module tb_i2c_arbiter;

    localparam int TMO = 8;

    typedef enum {M_WAIT, M_START, M_BUSY, M_DONE, M_GAP} mph_t;
    typedef struct {
        logic         id;
        logic         is_err;
        logic [6:0]   addr;
        logic [127:0] data;
        logic [4:0]   packets;
        logic         rw;
        logic [127:0] rd;
    } exp_t;
    typedef struct {
        int           d;
        int           l;
        logic [127:0] rdv;
    } plan_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req [2];
    logic [6:0]   addr [2];
    logic [127:0] data [2];
    logic [4:0]   pkts [2];
    logic         rw [2];
    logic         r0_grant, r0_done, r0_err, r1_grant, r1_done, r1_err;
    logic [127:0] rd_data, m_data;
    logic [6:0]   m_addr;
    logic [4:0]   m_packets;
    logic         m_rw, m_start;
    logic         m_ready = 1'b1;
    logic [127:0] m_data_out = '0;

    i2c_arbiter #(.START_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .r0_req(req[0]), .r0_addr(addr[0]), .r0_data(data[0]), .r0_packets(pkts[0]), .r0_rw(rw[0]),
        .r1_req(req[1]), .r1_addr(addr[1]), .r1_data(data[1]), .r1_packets(pkts[1]), .r1_rw(rw[1]),
        .r0_grant(r0_grant), .r0_done(r0_done), .r0_err(r0_err),
        .r1_grant(r1_grant), .r1_done(r1_done), .r1_err(r1_err),
        .rd_data(rd_data), .m_addr(m_addr), .m_data(m_data), .m_packets(m_packets),
        .m_rw(m_rw), .m_start(m_start), .m_ready(m_ready), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   exp_q[$];
    plan_t  plan_q[$];
    mph_t   mph = M_WAIT;
    logic   active [2] = '{1'b0, 1'b0};
    logic   pending [2] = '{1'b0, 1'b0};
    int     left [2] = '{0, 0};
    int     req_pct = 0;
    int     mcnt = 0;
    int     stall = 0;
    int     cur_l = 1;
    logic   cur = 1'b0;
    logic   cur_err = 1'b0;
    logic [127:0] cur_rdv = '0;
    logic   model_last = 1'b1;
    logic [127:0] model_rd = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit tb_idle();
        return !active[0] && !active[1] && !pending[0] && !pending[1] &&
               left[0] == 0 && left[1] == 0 && mph == M_WAIT && exp_q.size() == 0;
    endfunction

    task automatic new_req(input int i);
        addr[i] = 7'($urandom());
        data[i] = rand128();
        rw[i]   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) pkts[i] = $urandom_range(0, 1) ? 5'd31 : 5'd0;
        else pkts[i] = 5'($urandom_range(1, 16));
        req[i] = 1'b1;
        pending[i] = 1'b1;
        left[i]--;
    endtask

    task automatic finish_req(input logic i);
        active[i] = 1'b0;
        req[i] = 1'b0;
        stall = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {r0_grant, r1_grant, r0_done, r1_done, r0_err, r1_err, m_start,
                              m_rw, m_packets, m_addr}, '0);
        check({tag, "_m_data"}, m_data, '0);
        check({tag, "_rd_data"}, rd_data, '0);
    endtask

    // One negedge of the requester and i2c_master models.
    task automatic step();
        exp_t  e;
        plan_t p;
        logic  w;
        if (mph == M_WAIT) begin
            if (m_start) begin
                check("grant_has_req", req[0] | req[1], 1'b1);
                if (req[0] && req[1]) w = ~model_last;
                else w = req[1];
                if (plan_q.size() > 0) p = plan_q.pop_front();
                else begin
                    p.d = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 1, TMO + 1)
                                                      : $urandom_range(0, TMO - 2);
                    p.l = $urandom_range(1, 6);
                    p.rdv = rand128();
                end
                e.id = w;
                e.is_err = (p.d >= TMO);
                e.addr = addr[w];
                e.data = data[w];
                e.packets = pkts[w];
                e.rw = rw[w];
                e.rd = (!e.is_err && rw[w]) ? p.rdv : model_rd;
                model_rd = e.rd;
                exp_q.push_back(e);
                cur = w;
                cur_err = e.is_err;
                cur_l = p.l;
                cur_rdv = p.rdv;
                active[w] = 1'b1;
                pending[w] = 1'b0;
                mcnt = cur_err ? TMO : p.d;
                stall = 0;
                mph = M_START;
            end else if (req[0] | req[1]) begin
                stall++;
                check("grant_latency", stall <= 3, 1'b1);
            end else begin
                stall = 0;
            end
        end
        if (mph == M_START) begin
            if (mcnt == 0 && cur_err) begin
                check("m_start_after_err", m_start, 1'b0);
                finish_req(cur);
                mph = M_WAIT;
            end else begin
                check("m_start_high", m_start, 1'b1);
                if (mcnt == 0) begin
                    m_ready = 1'b0;
                    m_data_out = rand128();
                    mcnt = cur_l;
                    mph = M_BUSY;
                end else begin
                    mcnt--;
                end
            end
        end else if (mph == M_BUSY) begin
            check("m_start_low", m_start, 1'b0);
            mcnt--;
            if (mcnt == 0) begin
                m_ready = 1'b1;
                m_data_out = cur_rdv;
                mph = M_DONE;
            end
        end else if (mph == M_DONE) begin
            finish_req(cur);
            model_last = cur;
            m_data_out = rand128();
            if ($urandom_range(0, 2) == 0) begin
                m_ready = 1'b0;
                mcnt = $urandom_range(1, 4);
                mph = M_GAP;
            end else begin
                mph = M_WAIT;
            end
        end else if (mph == M_GAP) begin
            check("gap_no_grant", {r1_grant, r0_grant}, 2'b00);
            mcnt--;
            if (mcnt == 0) begin
                m_ready = 1'b1;
                mph = M_WAIT;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (active[i]) begin
                if (req[i] && $urandom_range(0, 4) == 0) req[i] = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    addr[i] = 7'($urandom());
                    data[i] = rand128();
                    pkts[i] = 5'($urandom());
                    rw[i]   = ~rw[i];
                end
            end else if (!pending[i] && left[i] > 0 && $urandom_range(0, 99) < req_pct) begin
                new_req(i);
            end
        end
    endtask

    task automatic run_until_idle(input string name, input int cap);
        bit done_ok = 1'b0;
        for (int c = 0; c < cap; c++) begin
            @(negedge clk);
            step();
            if (tb_idle()) begin
                done_ok = 1'b1;
                break;
            end
        end
        check(name, done_ok, 1'b1);
    endtask

    // Monitor: pops one expectation per done/err pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("one_grant", r0_grant & r1_grant, 1'b0);
                if (r0_done | r1_done | r0_err | r1_err) begin
                    check("one_resp", 32'(r0_done) + 32'(r1_done) + 32'(r0_err) + 32'(r1_err), 1);
                    check("outstanding", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("resp_kind", r0_err | r1_err, e.is_err);
                        check("resp_id", r1_done | r1_err, e.id);
                        check("resp_grant", {r1_grant, r0_grant},
                              e.is_err ? 2'b00 : (e.id ? 2'b10 : 2'b01));
                        check("resp_m_addr", m_addr, e.addr);
                        check("resp_m_data", m_data, e.data);
                        check("resp_m_packets", m_packets, e.packets);
                        check("resp_m_rw", m_rw, e.rw);
                        check("resp_m_start", m_start, 1'b0);
                        check("resp_rd_data", rd_data, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        bit reached;
        plan_t p;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; addr[i] = '0; data[i] = '0; pkts[i] = '0; rw[i] = 1'b0;
        end
        #1;
        check_reset_outputs("reset_init");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");

        // Both requesters arrive together: r0 write, r1 read, then alternate.
        reset = 1'b1;
        addr[0] = 7'h58; data[0] = 128'h3001; pkts[0] = 5'd2; rw[0] = 1'b0;
        addr[1] = 7'h21; data[1] = rand128(); pkts[1] = 5'd16; rw[1] = 1'b1;
        req[0] = 1'b1; req[1] = 1'b1; pending[0] = 1'b1; pending[1] = 1'b1;
        left[0] = 1; left[1] = 1; req_pct = 100;
        p.d = 3;       p.l = 20; p.rdv = rand128();                       plan_q.push_back(p);
        p.d = 1;       p.l = 3;  p.rdv = 128'h0123456789ABCDEF0123456789ABCDEF; plan_q.push_back(p);
        p.d = TMO + 2; p.l = 1;  p.rdv = rand128();                       plan_q.push_back(p);
        p.d = TMO - 1; p.l = 2;  p.rdv = rand128();                       plan_q.push_back(p);
        run_until_idle("directed_idle", 400);

        // Random traffic.
        left[0] = 60; left[1] = 60; req_pct = 30;
        run_until_idle("random_idle", 20000);

        // Reset while the master is busy, then both requesters pending.
        left[1] = 1; req_pct = 100;
        p.d = 0; p.l = 50; p.rdv = rand128(); plan_q.push_back(p);
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            step();
            if (mph == M_BUSY) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_busy", reached, 1'b1);
        @(negedge clk);
        step();
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_mid_busy");
        exp_q.delete();
        plan_q.delete();
        mph = M_WAIT; m_ready = 1'b1; model_last = 1'b1; model_rd = '0; stall = 0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; pending[i] = 1'b1; left[i] = 0; req[i] = 1'b1;
            addr[i] = 7'($urandom()); data[i] = rand128(); pkts[i] = 5'($urandom_range(1, 16));
            rw[i] = 1'($urandom_range(0, 1));
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_mid_busy_hold");
        reset = 1'b1;
        @(negedge clk);
        check("r0_first_after_reset", {r1_grant, r0_grant}, 2'b01);
        step();
        run_until_idle("post_reset_idle", 400);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter START_TIMEOUT, default 255: max cycles in START waiting for m_ready to fall before abort.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rN_req  input  1  (N=0,1) requester N wants one bus transaction; held high until rN_done or rN_err.
REQ-005 rN_addr  input  7  7-bit I2C device address of requester N.
REQ-006 rN_data  input  128  write payload of requester N, byte 0 in bits [7:0].
REQ-007 rN_packets  input  5  byte count of requester N, 1..16.
REQ-008 rN_rw  input  1  requester N direction, 1=read, 0=write.
REQ-009 rN_grant  output  1  high while requester N owns the master (START through DONE).
REQ-010 rN_done  output  1  one-cycle pulse: requester N transaction completed.
REQ-011 rN_err  output  1  one-cycle pulse: requester N transaction aborted on timeout.
REQ-012 rd_data  output  128  read data captured at end of last completed read.
REQ-013 m_addr/m_data/m_packets/m_rw  output  7/128/5/1  request fields driven to i2c_master.
REQ-014 m_start  output  1  start strobe to i2c_master.
REQ-015 m_ready  input  1  i2c_master idle flag (high = idle).
REQ-016 m_data_out  input  128  i2c_master read data.

Function
REQ-017 FSM states: IDLE, START, BUSY, DONE; 2-bit encoding; no other reachable state.
REQ-018 IDLE: if m_ready=1 and any rN_req=1, select winner, register its addr/data/packets/rw onto m_* outputs, set its grant, go START next cycle.
REQ-019 IDLE with m_ready=0: no grant issued, stay IDLE.
REQ-020 Arbitration round-robin: a 1-bit last-winner flag; on simultaneous requests the requester not served last wins; after reset requester 0 has priority.
REQ-021 m_* request fields frozen from grant to return to IDLE; later changes on rN_* inputs ignored.
REQ-022 START: m_start=1; when m_ready=0 sampled, go BUSY with m_start=0 from that cycle's next edge.
REQ-023 START timeout: counter cleared on entry, increments each START cycle; at count START_TIMEOUT without m_ready=0, pulse rN_err, m_start=0, drop grant, go IDLE.
REQ-024 BUSY: m_start=0; when m_ready=1 sampled, go DONE; if rw=1 capture m_data_out into rd_data on that edge.
REQ-025 DONE: rN_done=1 for exactly this cycle, grant dropped at its end, last-winner updated, go IDLE.
REQ-026 Minimum gap: a new grant is issued no earlier than the cycle after DONE (IDLE always lasts >=1 cycle).
REQ-027 Requester deasserting rN_req after grant: transaction still completes; done/err still pulsed.
REQ-028 Write transactions leave rd_data unchanged.
REQ-029 At most one rN_grant, one rN_done, one rN_err high in any cycle; done and err never both high.
REQ-030 m_packets passed through unchanged; values 0 or >16 not checked or corrected.

Reset
REQ-031 reset low: state=IDLE immediately, m_start=0, all grants/done/err=0, rd_data=0, m_addr/m_data/m_packets/m_rw=0, last-winner points to requester 1 (so requester 0 wins first), timeout counter=0.
REQ-032 reset asserted mid-transaction aborts it with no done/err pulse; after release, arbitration restarts per REQ-031.
REQ-033 Outputs change only on clk edges after reset release; reset release needs no synchronizer inside this block.

Verification
REQ-034 r0_req with addr 0x58, data 0x3001, packets 2, rw 0; model master drops m_ready 3 cycles after m_start, raises 20 cycles later -> r0_grant, m_start high until m_ready falls, r0_done one pulse, rd_data stays 0.
REQ-035 r0_req and r1_req asserted same cycle after reset, both held -> r0 served first, r1 second, then r0 again; never two grants.
REQ-036 r1_req read, packets 16; master returns m_data_out=0x0123...EF at ready rise -> rd_data equals that value on r1_done cycle.
REQ-037 r0_req with master holding m_ready=1 forever, START_TIMEOUT=8 -> r0_err pulse after 8 START cycles, m_start low, back to IDLE, r1_req then granted.
REQ-038 reset low during BUSY -> all outputs 0 same cycle, no done pulse; after release pending r1_req and r0_req -> r0 granted first.
REQ-039 r0_req dropped one cycle after grant -> transaction completes, r0_done pulses once.
